// File: rtl/dab_param_sequencer_pkg.sv
// DAB parameter sequencer shared types and limits.
// State codes, default legal ranges and ramp helpers.
package dab_param_sequencer_pkg;

  localparam int PHI_MAX_D = 255;
  localparam int FS_MIN_D  = 500;
  localparam int FS_MAX_D  = 250000;
  localparam int DT_MIN_D  = 1;
  localparam int PHI_LW    = 11;

  typedef logic signed [PHI_LW-1:0] wide_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SOFTSTART = 3'd1,
    RUN       = 3'd2,
    FAULT     = 3'd3
  } state_t;

  typedef struct packed {
    logic signed [8:0]  t1;
    logic signed [8:0]  t2;
    logic signed [8:0]  phi;
    logic signed [18:0] fs;
    logic [7:0]         dt;
  } shadow_t;

  function automatic wide_t sx(input logic signed [8:0] v);
    return {{2{v[8]}}, v};
  endfunction

  // next value moving q toward tgt by min(step,|diff|); step 0 jumps
  function automatic logic signed [8:0] ramp_next(
    input logic signed [8:0] q,
    input logic signed [8:0] tgt,
    input logic [7:0]        step
  );
    wide_t d;
    wide_t m;
    wide_t s;
    d = sx(tgt) - sx(q);
    m = d[PHI_LW-1] ? -d : d;
    s = {3'b000, step};
    if (step == 8'd0 || s >= m) return tgt;
    if (d[PHI_LW-1]) return q - $signed({1'b0, step});
    return q + $signed({1'b0, step});
  endfunction

endpackage

// File: rtl/dab_param_sequencer_if.sv
// Host request / modulator output bundle of the sequencer.
// master = host side, slave = sequencer side.
interface dab_param_sequencer_if;

  logic               CE;
  logic               enable;
  logic               fault;
  logic               trigger;
  logic               load;
  logic signed [8:0]  t1_req;
  logic signed [8:0]  t2_req;
  logic signed [8:0]  phi_req;
  logic signed [18:0] fs_req;
  logic [7:0]         dt_req;
  logic [7:0]         step;
  logic signed [8:0]  t1_out;
  logic signed [8:0]  t2_out;
  logic signed [8:0]  phi_out;
  logic signed [18:0] fs_out;
  logic [7:0]         dt_out;
  logic               run;
  logic               busy;
  logic               upd_ack;
  logic [2:0]         state;

  modport master (
    output CE, enable, fault, trigger, load,
    output t1_req, t2_req, phi_req, fs_req, dt_req, step,
    input  t1_out, t2_out, phi_out, fs_out, dt_out,
    input  run, busy, upd_ack, state
  );

  modport slave (
    input  CE, enable, fault, trigger, load,
    input  t1_req, t2_req, phi_req, fs_req, dt_req, step,
    output t1_out, t2_out, phi_out, fs_out, dt_out,
    output run, busy, upd_ack, state
  );

endinterface

// File: rtl/dab_step_ramp.sv
// Registered signed value stepping toward a target.
// Moves by min(step,|diff|) per advance strobe; clear wins.
module dab_step_ramp
  import dab_param_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  input  logic              clr,
  input  logic signed [8:0] target,
  input  logic [7:0]        step,
  output logic signed [8:0] q
);

  // value register: clear to zero, else step on advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (adv) begin
      q <= ramp_next(q, target, step);
    end
  end

endmodule

// File: rtl/dab_param_sequencer.sv
// DAB operating-point sequencer: shadowed requests applied
// on period edges, soft-start, phi ramp and fault safe state.
module dab_param_sequencer
  import dab_param_sequencer_pkg::*;
#(
  parameter int PHI_MAX = PHI_MAX_D,
  parameter int FS_MIN  = FS_MIN_D,
  parameter int FS_MAX  = FS_MAX_D,
  parameter int DT_MIN  = DT_MIN_D
) (
  input logic                  clk,
  input logic                  rst,
  dab_param_sequencer_if.slave bus
);

  localparam logic signed [8:0]  PM9  = 9'(PHI_MAX);
  localparam wide_t              PM11 = wide_t'(PHI_MAX);
  localparam logic signed [18:0] FMIN = 19'(FS_MIN);
  localparam logic signed [18:0] FMAX = 19'(FS_MAX);
  localparam logic [7:0]         DMIN = 8'(DT_MIN);

  state_t             state_q;
  state_t             state_d;
  shadow_t            sh_q;
  shadow_t            cap;
  wide_t              lim;
  logic               pending_q;
  logic               trig_q;
  logic               upd_q;
  logic signed [18:0] fs_q;
  logic [7:0]         dt_q;
  logic               act;
  logic               clr;
  logic               adv_tt;
  logic               adv_phi;
  logic               apply;
  logic               ss_load;
  logic               done;
  logic [7:0]         tt_step;

  assign act = bus.CE & bus.trigger & ~trig_q;

  // saturate request inputs to the modulator's legal range
  always_comb begin
    cap = '0;
    cap.t1 = bus.t1_req;
    if (bus.t1_req[8]) cap.t1 = '0;
    else if (bus.t1_req > PM9) cap.t1 = PM9;
    cap.t2 = bus.t2_req;
    if (bus.t2_req[8]) cap.t2 = '0;
    else if (bus.t2_req > PM9) cap.t2 = PM9;
    lim = sx(cap.t2) - sx(cap.t1) + PM11;
    cap.phi = bus.phi_req;
    if (sx(bus.phi_req) > lim) cap.phi = lim[8:0];
    if (cap.phi < -PM9) cap.phi = -PM9;
    cap.fs = bus.fs_req;
    if (bus.fs_req < FMIN) cap.fs = FMIN;
    else if (bus.fs_req > FMAX) cap.fs = FMAX;
    cap.dt = (bus.dt_req < DMIN) ? DMIN : bus.dt_req;
  end

  // next state and ramp/apply strobes
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    adv_tt  = 1'b0;
    adv_phi = 1'b0;
    apply   = 1'b0;
    ss_load = 1'b0;
    tt_step = (state_q == RUN) ? 8'd0 : bus.step;
    done    = (ramp_next(bus.t1_out, sh_q.t1, tt_step) == sh_q.t1)
           && (ramp_next(bus.t2_out, sh_q.t2, tt_step) == sh_q.t2);
    if (bus.fault) begin
      state_d = FAULT;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (act && bus.enable) begin
            state_d = SOFTSTART;
            ss_load = 1'b1;
            clr     = 1'b1;
          end
        end
        SOFTSTART: begin
          if (act) begin
            if (!bus.enable) begin
              state_d = IDLE;
              clr     = 1'b1;
            end else begin
              adv_tt = 1'b1;
              if (done) state_d = RUN;
            end
          end
        end
        RUN: begin
          if (act) begin
            if (!bus.enable) begin
              state_d = IDLE;
              clr     = 1'b1;
            end else begin
              adv_phi = 1'b1;
              if (pending_q) begin
                adv_tt = 1'b1;
                apply  = 1'b1;
              end
            end
          end
        end
        FAULT: begin
          if (!bus.enable) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state, edge detect, pending flag and ack pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      trig_q    <= 1'b0;
      pending_q <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      upd_q   <= apply;
      if (bus.CE) trig_q <= bus.trigger;
      if (bus.fault) pending_q <= 1'b0;
      else if (bus.load && bus.CE) pending_q <= 1'b1;
      else if (apply) pending_q <= 1'b0;
    end
  end

  // shadow capture; latest load wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q <= '0;
    end else if (bus.load && bus.CE) begin
      sh_q <= cap;
    end
  end

  // fs/dt take the shadow at start and on apply
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fs_q <= FMIN;
      dt_q <= DMIN;
    end else if (ss_load || apply) begin
      fs_q <= sh_q.fs;
      dt_q <= sh_q.dt;
    end
  end

  dab_step_ramp u_t1 (
    .clk    (clk),
    .rst    (rst),
    .adv    (adv_tt),
    .clr    (clr),
    .target (sh_q.t1),
    .step   (tt_step),
    .q      (bus.t1_out)
  );

  dab_step_ramp u_t2 (
    .clk    (clk),
    .rst    (rst),
    .adv    (adv_tt),
    .clr    (clr),
    .target (sh_q.t2),
    .step   (tt_step),
    .q      (bus.t2_out)
  );

  dab_step_ramp u_phi (
    .clk    (clk),
    .rst    (rst),
    .adv    (adv_phi),
    .clr    (clr),
    .target (sh_q.phi),
    .step   (bus.step),
    .q      (bus.phi_out)
  );

  assign bus.fs_out  = fs_q;
  assign bus.dt_out  = dt_q;
  assign bus.state   = state_q;
  assign bus.run     = (state_q == SOFTSTART) || (state_q == RUN);
  assign bus.upd_ack = upd_q;
  assign bus.busy    = pending_q
                    || (bus.phi_out != sh_q.phi)
                    || (state_q == SOFTSTART);

endmodule

// File: tb/tb_dab_param_sequencer.sv
// Scoreboard bench for dab_param_sequencer.
// Stimulus queues expected outputs; a monitor pops and compares.
module tb_dab_param_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  event kick;

  dab_param_sequencer_if bus();

  dab_param_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string nm;
    int    due;
    int    t1, t2, phi, fs, dt, run, busy, ack, st;
  } exp_t;

  exp_t sbq[$];

  function automatic exp_t mk(string nm, int t1, int t2, int phi,
                              int fs, int dt, int run, int busy,
                              int ack, int st);
    exp_t e;
    e.nm = nm; e.due = 0;
    e.t1 = t1; e.t2 = t2; e.phi = phi; e.fs = fs; e.dt = dt;
    e.run = run; e.busy = busy; e.ack = ack; e.st = st;
    return e;
  endfunction

  task automatic chk(string nm, string f, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s.%s got=%0d want=%0d", nm, f, got, want);
    end
  endtask

  // monitor: compare every expectation whose sample time has come
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or kick);
      #1;
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        chk(e.nm, "t1", bus.t1_out, e.t1);
        chk(e.nm, "t2", bus.t2_out, e.t2);
        chk(e.nm, "phi", bus.phi_out, e.phi);
        chk(e.nm, "fs", bus.fs_out, e.fs);
        chk(e.nm, "dt", bus.dt_out, e.dt);
        chk(e.nm, "run", bus.run, e.run);
        chk(e.nm, "busy", bus.busy, e.busy);
        chk(e.nm, "ack", bus.upd_ack, e.ack);
        chk(e.nm, "state", bus.state, e.st);
      end
    end
  end

  // expect e right after the coming clock edge (call at negedge)
  task automatic next_cycle(exp_t e);
    e.due = cyc + 1;
    sbq.push_back(e);
  endtask

  // expect e now, between edges
  task automatic now_check(exp_t e);
    e.due = cyc;
    sbq.push_back(e);
    ->kick;
    #2;
  endtask

  task automatic set_req(int t1, int t2, int phi, int fs, int dt,
                         int st);
    bus.t1_req  = 9'(t1);
    bus.t2_req  = 9'(t2);
    bus.phi_req = 9'(phi);
    bus.fs_req  = 19'(fs);
    bus.dt_req  = 8'(dt);
    bus.step    = 8'(st);
  endtask

  task automatic do_load();
    @(negedge clk);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  // one switching period: trigger rises, optionally with a load
  task automatic period(exp_t e, bit ld);
    @(negedge clk);
    bus.trigger = 1'b1;
    bus.load = ld;
    next_cycle(e);
    @(negedge clk);
    bus.trigger = 1'b0;
    bus.load = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    bus.CE = 1'b1;
    bus.enable = 1'b0;
    bus.fault = 1'b0;
    bus.trigger = 1'b0;
    bus.load = 1'b0;
    set_req(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    now_check(mk("reset", 0, 0, 0, 500, 1, 0, 0, 0, 0));
    rst = 1'b0;

    // soft-start
    set_req(200, 150, 30, 20000, 5, 50);
    do_load();
    now_check(mk("loaded", 0, 0, 0, 500, 1, 0, 1, 0, 0));
    bus.enable = 1'b1;
    period(mk("ss0", 0, 0, 0, 20000, 5, 1, 1, 0, 1), 0);
    period(mk("ss1", 50, 50, 0, 20000, 5, 1, 1, 0, 1), 0);
    period(mk("ss2", 100, 100, 0, 20000, 5, 1, 1, 0, 1), 0);
    period(mk("ss3", 150, 150, 0, 20000, 5, 1, 1, 0, 1), 0);
    period(mk("ss4", 200, 150, 0, 20000, 5, 1, 1, 0, 2), 0);
    period(mk("run0", 200, 150, 30, 20000, 5, 1, 0, 1, 2), 0);

    // phi saturation to t2-t1+255
    set_req(255, 147, 200, 20000, 5, 50);
    do_load();
    now_check(mk("hold", 200, 150, 30, 20000, 5, 1, 1, 0, 2));
    period(mk("sat0", 255, 147, 80, 20000, 5, 1, 1, 1, 2), 0);
    period(mk("sat1", 255, 147, 130, 20000, 5, 1, 1, 0, 2), 0);
    period(mk("sat2", 255, 147, 147, 20000, 5, 1, 0, 0, 2), 0);

    // negative floor, immediate step
    set_req(0, 0, -256, 20000, 5, 0);
    do_load();
    period(mk("neg", 0, 0, -255, 20000, 5, 1, 0, 1, 2), 0);
    set_req(0, 0, 0, 20000, 5, 0);
    do_load();
    period(mk("zero", 0, 0, 0, 20000, 5, 1, 0, 1, 2), 0);

    // ramp step 7
    set_req(0, 0, 20, 20000, 5, 7);
    do_load();
    period(mk("r7a", 0, 0, 7, 20000, 5, 1, 1, 1, 2), 0);
    period(mk("r7b", 0, 0, 14, 20000, 5, 1, 1, 0, 2), 0);
    period(mk("r7c", 0, 0, 20, 20000, 5, 1, 0, 0, 2), 0);

    // period-boundary apply with fs/dt clamping
    set_req(0, 0, 20, 260000, 0, 7);
    do_load();
    now_check(mk("fshold", 0, 0, 20, 20000, 5, 1, 1, 0, 2));
    period(mk("fsapp", 0, 0, 20, 250000, 1, 1, 0, 1, 2), 0);
    now_check(mk("ackone", 0, 0, 20, 250000, 1, 1, 0, 0, 2));

    // load on the apply edge: old shadow applied, new one pending
    set_req(5, 5, 20, 260000, 0, 7);
    do_load();
    set_req(9, 9, 20, 260000, 0, 7);
    period(mk("sameA", 5, 5, 20, 250000, 1, 1, 1, 1, 2), 1);
    period(mk("sameB", 9, 9, 20, 250000, 1, 1, 0, 1, 2), 0);

    // CE low freezes load and trigger
    bus.CE = 1'b0;
    set_req(100, 100, 20, 260000, 0, 7);
    do_load();
    period(mk("ceoff", 9, 9, 20, 250000, 1, 1, 0, 0, 2), 0);

    // fault while CE low
    @(negedge clk);
    bus.fault = 1'b1;
    next_cycle(mk("fault", 0, 0, 0, 250000, 1, 0, 1, 0, 3));
    @(negedge clk);
    bus.fault = 1'b0;
    repeat (3) @(negedge clk);
    now_check(mk("fhold", 0, 0, 0, 250000, 1, 0, 1, 0, 3));
    @(negedge clk);
    bus.enable = 1'b0;
    next_cycle(mk("fexit", 0, 0, 0, 250000, 1, 0, 1, 0, 0));
    @(negedge clk);
    bus.CE = 1'b1;

    // restart, then async reset mid-run
    set_req(5, 5, 40, 260000, 0, 0);
    do_load();
    now_check(mk("reload", 0, 0, 0, 250000, 1, 0, 1, 0, 0));
    bus.enable = 1'b1;
    period(mk("rs0", 0, 0, 0, 250000, 1, 1, 1, 0, 1), 0);
    period(mk("rs1", 5, 5, 0, 250000, 1, 1, 1, 0, 2), 0);
    period(mk("rs2", 5, 5, 40, 250000, 1, 1, 0, 1, 2), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    now_check(mk("arst", 0, 0, 0, 500, 1, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL leftover got=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
